gb_pulse_generator: RTL and testbench

Waveform stage for APU Channel 1 (pulse with sweep), directly downstream of the sweep function. Consumes the swept shadow frequency and the overflow flag, runs the frequency timer and the 8-step duty sequencer, applies the length counter and DAC gating, and emits a registered 4-bit digital sample to the mixer. The envelope volume arrives as an input from the envelope block.

---
 rtl/gb_pulse_generator.sv | 157 +++++++++++++++
 tb/tb_gb_pulse_generator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_pulse_generator.sv
`default_nettype none
// ============================================================================
// Module   : gb_pulse_generator
// Purpose  : Waveform stage for APU channel 1 (pulse with sweep). Runs the
//            prescaled frequency timer and the 8-step duty sequencer, applies
//            the length counter and the DAC/overflow gating, and produces a
//            registered 4-bit sample for the mixer.
// Ports    : clk           - system clock (2^22 Hz)
//            rst_n         - asynchronous active-low reset
//            trigger       - channel trigger pulse, one clk wide
//            frequency     - 11-bit shadow frequency from the sweep unit
//            overflow      - sweep overflow, mutes the channel
//            duty          - duty pattern select
//            volume        - current envelope volume
//            dac_enable    - channel DAC power
//            clk_length    - length tick from the frame sequencer
//            length_enable - length counting enabled
//            length_write  - length register write strobe
//            length_load   - raw 6-bit length register value
//            channel_on    - channel active status
//            sample        - 4-bit digital sample to the mixer
// Revision : 1.0 - initial release
// ============================================================================
module gb_pulse_generator #(
    parameter int unsigned PRESCALE   = 4,   // clks per timer tick, >= 1
    parameter int unsigned LENGTH_MAX = 64   // length full scale, >= 63
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger,
    input  logic [10:0] frequency,
    input  logic        overflow,
    input  logic [1:0]  duty,
    input  logic [3:0]  volume,
    input  logic        dac_enable,
    input  logic        clk_length,
    input  logic        length_enable,
    input  logic        length_write,
    input  logic [5:0]  length_load,
    output logic        channel_on,
    output logic [3:0]  sample
);

    localparam int unsigned c_ps_w      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned c_len_w     = $clog2(LENGTH_MAX + 1);
    localparam logic [11:0] c_timer_max = 12'd2048;

    logic [c_ps_w-1:0]  prescale_q,   prescale_d;
    logic [11:0]        timer_q,      timer_d;
    logic [2:0]         step_q,       step_d;
    logic [c_len_w-1:0] length_q,     length_d;
    logic               channel_on_q, channel_on_d;
    logic [3:0]         sample_q,     sample_d;

    logic               w_tick;
    logic [11:0]        w_reload_value;
    logic [7:0]         w_pattern;
    logic               w_length_expire;

    // ------------------------------------------------------------------------
    // Prescaler, period timer and duty step
    // ------------------------------------------------------------------------
    always_comb begin
        w_tick         = (prescale_q == c_ps_w'(PRESCALE - 1));
        // frequency == 0 gives 2048, which still fits in 12 bits
        w_reload_value = c_timer_max - {1'b0, frequency};

        prescale_d = prescale_q;
        timer_d    = timer_q;
        step_d     = step_q;

        if (trigger) begin
            // Restart the period from scratch; the duty position is kept
            prescale_d = '0;
            timer_d    = w_reload_value;
        end else begin
            prescale_d = w_tick ? '0 : prescale_q + c_ps_w'(1);
            if (w_tick) begin
                if (timer_q == 12'd1) begin
                    timer_d = w_reload_value;
                    step_d  = step_q + 3'd1;
                end else begin
                    timer_d = timer_q - 12'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Length counter and channel enable
    // ------------------------------------------------------------------------
    always_comb begin
        length_d        = length_q;
        channel_on_d    = channel_on_q;
        w_length_expire = 1'b0;

        if (trigger) begin
            // Trigger masks length ticks, writes and overflow in this clk
            channel_on_d = dac_enable;
            if (length_q == '0) begin
                length_d = c_len_w'(LENGTH_MAX);
            end
        end else begin
            if (length_write) begin
                length_d = c_len_w'(LENGTH_MAX) - c_len_w'(length_load);
            end else if (clk_length && length_enable && (length_q != '0)) begin
                length_d        = length_q - c_len_w'(1);
                w_length_expire = (length_q == c_len_w'(1));
            end

            if (overflow || !dac_enable || w_length_expire) begin
                channel_on_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Duty pattern lookup (bit index = step) and sample gating
    // ------------------------------------------------------------------------
    always_comb begin
        w_pattern = 8'b0000_0001;
        case (duty)
            2'b00:   w_pattern = 8'b0000_0001;
            2'b01:   w_pattern = 8'b1000_0001;
            2'b10:   w_pattern = 8'b1000_0111;
            default: w_pattern = 8'b0111_1110;
        endcase

        sample_d = (channel_on_q && w_pattern[step_q]) ? volume : 4'd0;
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q   <= '0;
            timer_q      <= c_timer_max;
            step_q       <= 3'd0;
            length_q     <= '0;
            channel_on_q <= 1'b0;
            sample_q     <= 4'd0;
        end else begin
            prescale_q   <= prescale_d;
            timer_q      <= timer_d;
            step_q       <= step_d;
            length_q     <= length_d;
            channel_on_q <= channel_on_d;
            sample_q     <= sample_d;
        end
    end

    assign channel_on = channel_on_q;
    assign sample     = sample_q;

endmodule
`default_nettype wire

// File: tb/tb_gb_pulse_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_gb_pulse_generator
// Purpose  : Self-checking bench for gb_pulse_generator. A behavioural model
//            counts clocks to the next duty step directly and tracks length,
//            enable and sample; outputs are compared on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gb_pulse_generator;

    localparam int P    = 4;
    localparam int LMAX = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trigger = 1'b0;
    logic [10:0] frequency = 11'd2047;
    logic        overflow = 1'b0;
    logic [1:0]  duty = 2'b10;
    logic [3:0]  volume = 4'd15;
    logic        dac_enable = 1'b1;
    logic        clk_length = 1'b0;
    logic        length_enable = 1'b0;
    logic        length_write = 1'b0;
    logic [5:0]  length_load = 6'd0;
    logic        channel_on;
    logic [3:0]  sample;

    always #5 clk = ~clk;

    gb_pulse_generator #(.PRESCALE(P), .LENGTH_MAX(LMAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trigger      (trigger),
        .frequency    (frequency),
        .overflow     (overflow),
        .duty         (duty),
        .volume       (volume),
        .dac_enable   (dac_enable),
        .clk_length   (clk_length),
        .length_enable(length_enable),
        .length_write (length_write),
        .length_load  (length_load),
        .channel_on   (channel_on),
        .sample       (sample)
    );

    int compared   = 0;
    int mismatched = 0;
    bit check_en   = 1'b0;

    // Model state: clocks left until the next duty step, step, length, enable
    int m_remaining;
    int m_step;
    int m_len;
    bit m_on;
    int m_sample;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Duty tables written as the set of high steps
    function automatic bit pat_high(input logic [1:0] d, input int s);
        case (d)
            2'd0:    return (s == 0);
            2'd1:    return (s == 0) || (s == 7);
            2'd2:    return (s <= 2) || (s == 7);
            default: return (s >= 1) && (s <= 6);
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int  per;
        int  nsmp;
        bit  expire;
        if (!rst_n) begin
            m_remaining = 2048 * P;
            m_step      = 0;
            m_len       = 0;
            m_on        = 1'b0;
            m_sample    = 0;
        end else begin
            nsmp   = (m_on && pat_high(duty, m_step)) ? int'(volume) : 0;
            per    = (2048 - int'(frequency)) * P;
            expire = 1'b0;
            if (trigger) begin
                m_remaining = per;
                m_on        = dac_enable;
                if (m_len == 0) m_len = LMAX;
            end else begin
                m_remaining--;
                if (m_remaining == 0) begin
                    m_step      = (m_step + 1) % 8;
                    m_remaining = per;
                end
                if (length_write) begin
                    m_len = LMAX - int'(length_load);
                end else if (clk_length && length_enable && m_len > 0) begin
                    m_len--;
                    expire = (m_len == 0);
                end
                m_on = m_on && !overflow && dac_enable && !expire;
            end
            m_sample = nsmp;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("channel_on", int'(channel_on), int'(m_on));
            check("sample", int'(sample), m_sample);
        end
    end

    // Advance n clocks; inputs change 2 time units after the rising edge,
    // and one-clk strobes are dropped after the edge that samples them.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            trigger      = 1'b0;
            clk_length   = 1'b0;
            length_write = 1'b0;
            overflow     = 1'b0;
        end
    endtask

    int lit_seq [8] = '{15, 15, 15, 0, 0, 0, 0, 15};

    initial begin
        // Reset state
        #1;
        check("reset_channel_on", int'(channel_on), 0);
        check("reset_sample", int'(sample), 0);
        cyc(3);
        rst_n    = 1'b1;
        check_en = 1'b1;
        cyc(3);

        // 1: duty 10 at the fastest period, literal waveform
        trigger = 1'b1;
        cyc(1);
        for (int k = 1; k <= 32; k++) begin
            cyc(1);
            @(negedge clk);
            check("t1_wave", int'(sample), lit_seq[(k - 1) / 4]);
        end
        check("t1_on", int'(channel_on), 1);

        // 2: frequency change mid-period applies at the next reload
        frequency = 11'd2040;
        duty      = 2'b00;
        trigger   = 1'b1;
        cyc(10);
        frequency = 11'd2044;
        cyc(90);

        // 3: length expiry after two ticks, then full-scale reload
        length_load  = 6'd62;
        length_write = 1'b1;
        cyc(1);
        length_enable = 1'b1;
        trigger       = 1'b1;
        cyc(4);
        clk_length = 1'b1;
        cyc(4);
        clk_length = 1'b1;
        cyc(1);
        @(negedge clk);
        check("t3_expired_on", int'(channel_on), 0);
        cyc(1);
        @(negedge clk);
        check("t3_expired_sample", int'(sample), 0);
        trigger = 1'b1;
        cyc(2);
        for (int i = 0; i < LMAX - 1; i++) begin
            clk_length = 1'b1;
            cyc(2);
        end
        @(negedge clk);
        check("t3_len63_on", int'(channel_on), 1);
        clk_length = 1'b1;
        cyc(1);
        @(negedge clk);
        check("t3_len64_on", int'(channel_on), 0);
        length_enable = 1'b0;

        // 4: overflow mutes; trigger overrides a coincident overflow
        trigger = 1'b1;
        cyc(5);
        overflow = 1'b1;
        cyc(1);
        @(negedge clk);
        check("t4_overflow_on", int'(channel_on), 0);
        trigger  = 1'b1;
        overflow = 1'b1;
        cyc(1);
        @(negedge clk);
        check("t4_trig_over_on", int'(channel_on), 1);

        // 5: DAC off: channel stays off while the step keeps moving
        dac_enable = 1'b0;
        duty       = 2'b11;
        frequency  = 11'd2047;
        trigger    = 1'b1;
        cyc(37);
        dac_enable = 1'b1;
        trigger    = 1'b1;
        cyc(40);

        // 6: asynchronous reset in mid-wave
        trigger = 1'b1;
        cyc(21);
        rst_n = 1'b0;
        #1;
        check("t6_async_on", int'(channel_on), 0);
        check("t6_async_sample", int'(sample), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        frequency = 11'd2046;
        trigger   = 1'b1;
        cyc(40);

        // Randomized traffic
        for (int it = 0; it < 4000; it++) begin
            trigger = ($urandom_range(0, 39) == 0);
            overflow = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 299) == 0) dac_enable = ~dac_enable;
            if ($urandom_range(0, 49) == 0) frequency = 11'(2030 + $urandom_range(0, 17));
            if ($urandom_range(0, 29) == 0) duty = 2'($urandom);
            if ($urandom_range(0, 9) == 0) volume = 4'($urandom);
            clk_length = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 99) == 0) length_enable = ~length_enable;
            if ($urandom_range(0, 79) == 0) begin
                length_write = 1'b1;
                length_load  = 6'($urandom);
            end
            if ($urandom_range(0, 1499) == 0) begin
                rst_n = 1'b0;
                cyc(2);
                rst_n = 1'b1;
            end
            cyc(1);
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
